rf_write_arbiter: RTL and testbench
===================================

Name: rf_write_arbiter

Overview:
- Drives the single register-file write port (write enable, destination index, write data) from two producers: the single-cycle ALU result and the variable-latency load result.
- Load results are buffered in a small in-order FIFO.
- Destination matches against unretired writes are forwarded back to the read side, so operand reads through the asynchronous read ports see the youngest pending value.
- Sits in the writeback stage, between the execute/load units and the register file.

Parameters:
- XLEN, 32, data width.
- DEPTH, 4, load-result FIFO entries (power of 2, minimum 2).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- alu_valid  in  1  ALU result present this cycle; no backpressure, always consumed.
- alu_rd  in  5  ALU destination register.
- alu_wdata  in  XLEN  ALU result.
- lsu_valid  in  1  load result offered.
- lsu_ready  out  1  arbiter can accept a load result.
- lsu_rd  in  5  load destination register.
- lsu_wdata  in  XLEN  load data.
- rf_en  out  1  registered write enable to the register file.
- rf_rd  out  5  registered write index.
- rf_wdata  out  XLEN  registered write data.
- rs1  in  5  read index 1, mirrored from decode.
- rs2  in  5  read index 2.
- fwd1_hit  out  1  rs1 matches an unretired write.
- fwd1_data  out  XLEN  value to use for rs1 when fwd1_hit = 1.
- fwd2_hit  out  1  rs2 matches an unretired write.
- fwd2_data  out  XLEN  value to use for rs2 when fwd2_hit = 1.
- pending  out  log2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (async, rst_n = 0):
  - rf_en = 0, rf_rd = 0, rf_wdata = 0.
  - FIFO empty, all entry live bits cleared, pending = 0.
  - The FIFO is fully flushed mid-operation with no partial drain.
- Output register:
  - rf_en, rf_rd and rf_wdata update every clock edge.
  - Latency from a selected source to the register-file write is 1 cycle.
- Source selection each cycle, in priority order:
  - (a) ALU, if alu_valid = 1 and alu_rd != 0. The FIFO head is not popped this cycle.
  - (b) Otherwise the FIFO head, if not empty. The head is popped. rf_en <= live bit of the head.
  - (c) Otherwise no source: rf_en <= 0 and rf_rd/rf_wdata hold their previous values.
- An ALU result with alu_rd = 0 is ignored. The FIFO head may drain in that cycle.
- LSU handshake:
  - lsu_ready = (pending < DEPTH), combinational from state only. It does not depend on a same-cycle pop.
  - A transfer occurs when lsu_valid & lsu_ready.
  - lsu_rd = 0 is accepted but not enqueued; pending is unchanged.
  - Otherwise the transfer enqueues {rd, data, live = 1} at the tail.
  - Push and pop in the same cycle: pending is unchanged.
  - Pointers wrap modulo DEPTH.
- WAW kill:
  - When the ALU is selected with rd = X, every FIFO entry already resident with rd == X has its live bit cleared.
  - A load accepted in the same cycle is younger than that ALU result and is not killed.
  - Killed entries still drain in order but produce rf_en = 0 and consume their drain slot.
- Forwarding (combinational), for each rsN != 0:
  - Priority 1: the youngest live FIFO entry with rd == rsN.
  - Priority 2: otherwise the output register, if rf_en = 1 and rf_rd == rsN.
  - Otherwise fwdN_hit = 0 and fwdN_data = 0.
  - rsN = 0 always gives hit = 0.
  - The ALU input of the current cycle is not a forwarding source.
- Entries are never dropped. Order among live loads is preserved.

Test Plan:
1. Release reset, ALU x5 = 0x0000_1234 for one cycle -> next cycle rf_en = 1, rf_rd = 5, rf_wdata = 0x0000_1234; the following cycle rf_en = 0.
2. Hold alu_valid with rd = 1 and offer 5 back-to-back loads x10..x14 -> 4 accepted, pending = 4, lsu_ready = 0 on the 5th. Drop alu_valid -> x10..x13 written on 4 consecutive cycles in order, lsu_ready returns to 1 after the first pop, then x14 is accepted.
3. Hold ALU busy (rd = 1), push load x7 = 0xAAAA, then ALU x7 = 0xBBBB, then release the ALU -> x7 written once with 0xBBBB; the killed entry drains with rf_en = 0 and pending returns to 0.
4. With ALU busy, push loads x3 = 0x11 then x3 = 0x22, drive rs1 = 3, rs2 = 0 -> fwd1_hit = 1, fwd1_data = 0x22, fwd2_hit = 0.
5. ALU rd = 0 with data 0xFFFF, plus load rd = 0 -> rf_en stays 0, lsu_ready = 1, pending stays 0.
6. With 3 entries queued and rf_en = 1, assert rst_n = 0 mid-cycle -> rf_en = 0 and pending = 0 immediately, no writes after reset release.

Source files
------------

// File: rtl/rf_write_arbiter.sv
// ---------------------------------------------------------------------------
// rf_write_arbiter
//
// Writeback-stage arbiter for the single register-file write port. Two
// producers compete for it: the single-cycle ALU (always wins, no
// backpressure) and the variable-latency load unit, whose results wait in a
// small in-order FIFO until the ALU leaves a slot free. An ALU write to a
// register kills older queued loads to the same register (WAW), so a stale
// load can never overwrite a newer ALU value. Pending writes are forwarded
// to the two asynchronous read ports so operand reads see the youngest value.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   alu_valid/alu_rd/alu_wdata ALU result (always consumed)
//   lsu_valid/lsu_ready        load-result handshake
//   lsu_rd/lsu_wdata           load destination and data
//   rf_en/rf_rd/rf_wdata       registered register-file write port
//   rs1/rs2                    read indices mirrored from decode
//   fwdN_hit/fwdN_data         forwarded value for rsN when hit is set
//   pending                    current load-FIFO occupancy
// ---------------------------------------------------------------------------
module rf_write_arbiter #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      alu_valid,
    input  logic [4:0]                alu_rd,
    input  logic [XLEN-1:0]           alu_wdata,
    input  logic                      lsu_valid,
    output logic                      lsu_ready,
    input  logic [4:0]                lsu_rd,
    input  logic [XLEN-1:0]           lsu_wdata,
    output logic                      rf_en,
    output logic [4:0]                rf_rd,
    output logic [XLEN-1:0]           rf_wdata,
    input  logic [4:0]                rs1,
    input  logic [4:0]                rs2,
    output logic                      fwd1_hit,
    output logic [XLEN-1:0]           fwd1_data,
    output logic                      fwd2_hit,
    output logic [XLEN-1:0]           fwd2_data,
    output logic [$clog2(DEPTH):0]    pending
);

    localparam int AW = $clog2(DEPTH);

    // Load FIFO storage. Data and index fields carry no reset; only the live
    // bits, pointers and occupancy are control state.
    logic [4:0]      rd_q   [DEPTH];
    logic [XLEN-1:0] data_q [DEPTH];
    logic [DEPTH-1:0] live_q;
    logic [AW-1:0]   head;
    logic [AW-1:0]   tail;
    logic [AW:0]     count;

    logic alu_sel;
    logic pop;
    logic push;

    // An ALU result to x0 is a no-op and must not block the FIFO drain.
    assign alu_sel   = alu_valid && (alu_rd != 5'd0);
    assign pop       = !alu_sel && (count != '0);
    // Ready is a function of state only; a same-cycle pop does not open a slot.
    assign lsu_ready = (count < (AW+1)'(DEPTH));
    // Loads to x0 complete the handshake but are dropped.
    assign push      = lsu_valid && lsu_ready && (lsu_rd != 5'd0);
    assign pending   = count;

    // Forwarding lookup: output register first, then walk the FIFO from
    // oldest to youngest so the youngest live match overrides everything.
    // The current-cycle ALU input is deliberately not a source.
    function automatic logic [XLEN:0] fwd_lookup(input logic [4:0] rs);
        logic [XLEN:0] res;
        logic [AW-1:0] idx;
        res = '0;
        if (rs != 5'd0) begin
            if (rf_en && (rf_rd == rs))
                res = {1'b1, rf_wdata};
            for (int i = 0; i < DEPTH; i++) begin
                idx = head + AW'(i);
                if (((AW+1)'(i) < count) && live_q[idx] && (rd_q[idx] == rs))
                    res = {1'b1, data_q[idx]};
            end
        end
        return res;
    endfunction

    assign {fwd1_hit, fwd1_data} = fwd_lookup(rs1);
    assign {fwd2_hit, fwd2_data} = fwd_lookup(rs2);

    // ---- FIFO enqueue: data fields ----
    always_ff @(posedge clk) begin
        if (push) begin
            rd_q[tail]   <= lsu_rd;
            data_q[tail] <= lsu_wdata;
        end
    end

    // ---- FIFO control and WAW kill ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head   <= '0;
            tail   <= '0;
            count  <= '0;
            live_q <= '0;
        end else begin
            // Kill older entries targeting the ALU's register. The push below
            // comes later, so a load accepted this cycle stays live.
            if (alu_sel) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (rd_q[i] == alu_rd)
                        live_q[i] <= 1'b0;
                end
            end
            if (push) begin
                live_q[tail] <= 1'b1;
                tail         <= tail + AW'(1);
            end
            if (pop)
                head <= head + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // ---- Output register: register-file write port ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_en    <= 1'b0;
            rf_rd    <= 5'd0;
            rf_wdata <= '0;
        end else if (alu_sel) begin
            rf_en    <= 1'b1;
            rf_rd    <= alu_rd;
            rf_wdata <= alu_wdata;
        end else if (pop) begin
            // A killed head still consumes its slot but writes nothing.
            rf_en    <= live_q[head];
            rf_rd    <= rd_q[head];
            rf_wdata <= data_q[head];
        end else begin
            rf_en    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rf_write_arbiter
//
// Self-checking bench for rf_write_arbiter. A queue-based reference model
// tracks the load FIFO and the expected register-file write; directed
// scenarios check fixed values and a randomized phase checks every output
// against the model each cycle.
// ---------------------------------------------------------------------------
module tb_rf_write_arbiter;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             alu_valid, lsu_valid, lsu_ready;
    logic [4:0]       alu_rd, lsu_rd, rf_rd, rs1, rs2;
    logic [XLEN-1:0]  alu_wdata, lsu_wdata, rf_wdata, fwd1_data, fwd2_data;
    logic             rf_en, fwd1_hit, fwd2_hit;
    logic [$clog2(DEPTH):0] pending;

    int checks = 0;
    int failures = 0;

    rf_write_arbiter #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_wdata(alu_wdata),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_wdata(lsu_wdata),
        .rf_en(rf_en), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
        .rs1(rs1), .rs2(rs2),
        .fwd1_hit(fwd1_hit), .fwd1_data(fwd1_data),
        .fwd2_hit(fwd2_hit), .fwd2_data(fwd2_data),
        .pending(pending)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct packed {
        logic            live;
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } ent_t;

    ent_t            mq[$];
    logic            m_en;
    logic [4:0]      m_rd;
    logic [XLEN-1:0] m_wd;

    task automatic model_reset();
        mq.delete();
        m_en = 1'b0;
        m_rd = 5'd0;
        m_wd = '0;
    endtask

    // Advance the model by one clock using the current DUT inputs.
    task automatic model_step();
        bit   ready;
        ent_t e;
        ready = (mq.size() < DEPTH);
        if (alu_valid && alu_rd != 5'd0) begin
            foreach (mq[i]) if (mq[i].rd == alu_rd) mq[i].live = 1'b0;
            m_en = 1'b1; m_rd = alu_rd; m_wd = alu_wdata;
        end else if (mq.size() > 0) begin
            e = mq.pop_front();
            m_en = e.live; m_rd = e.rd; m_wd = e.data;
        end else begin
            m_en = 1'b0;
        end
        if (lsu_valid && ready && lsu_rd != 5'd0)
            mq.push_back('{live: 1'b1, rd: lsu_rd, data: lsu_wdata});
    endtask

    // {hit, data} the model expects for read index rs.
    function automatic logic [XLEN:0] model_fwd(input logic [4:0] rs);
        if (rs == 5'd0) return '0;
        for (int i = mq.size() - 1; i >= 0; i--)
            if (mq[i].live && mq[i].rd == rs) return {1'b1, mq[i].data};
        if (m_en && m_rd == rs) return {1'b1, m_wd};
        return '0;
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid = 1'b0; alu_rd = 5'd0; alu_wdata = '0;
        lsu_valid = 1'b0; lsu_rd = 5'd0; lsu_wdata = '0;
        rs1 = 5'd0; rs2 = 5'd0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (rf_en !== 1'b0) begin failures++; $display("FAIL reset_rf_en got=%0b exp=0", rf_en); end
        checks++; if (rf_rd !== 5'd0) begin failures++; $display("FAIL reset_rf_rd got=%0d exp=0", rf_rd); end
        checks++; if (rf_wdata !== '0) begin failures++; $display("FAIL reset_rf_wdata got=%h exp=0", rf_wdata); end
        checks++; if (pending !== '0) begin failures++; $display("FAIL reset_pending got=%0d exp=0", pending); end
        checks++; if (lsu_ready !== 1'b1) begin failures++; $display("FAIL reset_lsu_ready got=%0b exp=1", lsu_ready); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_alu_single();
        alu_valid = 1'b1; alu_rd = 5'd5; alu_wdata = 32'h0000_1234;
        tick();
        alu_valid = 1'b0;
        checks++; if (rf_en !== 1'b1) begin failures++; $display("FAIL alu_en got=%0b exp=1", rf_en); end
        checks++; if (rf_rd !== 5'd5) begin failures++; $display("FAIL alu_rd got=%0d exp=5", rf_rd); end
        checks++; if (rf_wdata !== 32'h0000_1234) begin failures++; $display("FAIL alu_wdata got=%h exp=00001234", rf_wdata); end
        tick();
        checks++; if (rf_en !== 1'b0) begin failures++; $display("FAIL alu_en_after got=%0b exp=0", rf_en); end
    endtask

    task automatic test_fifo_full();
        alu_valid = 1'b1; alu_rd = 5'd1; alu_wdata = 32'hC0DE_0001;
        lsu_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            lsu_rd = 5'(10 + k); lsu_wdata = 32'(256 + k);
            #1;
            checks++; if (lsu_ready !== 1'b1) begin failures++; $display("FAIL fill_ready k=%0d got=%0b exp=1", k, lsu_ready); end
            tick();
        end
        lsu_rd = 5'd14; lsu_wdata = 32'(256 + 4);
        #1;
        checks++; if (lsu_ready !== 1'b0) begin failures++; $display("FAIL full_ready got=%0b exp=0", lsu_ready); end
        checks++; if (pending !== 3'd4) begin failures++; $display("FAIL full_pending got=%0d exp=4", pending); end
        checks++; if (rf_en !== 1'b1 || rf_rd !== 5'd1) begin failures++; $display("FAIL busy_alu got en=%0b rd=%0d exp en=1 rd=1", rf_en, rf_rd); end
        alu_valid = 1'b0;
        tick();
        checks++; if (rf_en !== 1'b1 || rf_rd !== 5'd10 || rf_wdata !== 32'd256) begin failures++; $display("FAIL drain0 got en=%0b rd=%0d d=%0d exp en=1 rd=10 d=256", rf_en, rf_rd, rf_wdata); end
        checks++; if (pending !== 3'd3) begin failures++; $display("FAIL drain0_pending got=%0d exp=3", pending); end
        checks++; if (lsu_ready !== 1'b1) begin failures++; $display("FAIL drain0_ready got=%0b exp=1", lsu_ready); end
        tick();
        lsu_valid = 1'b0;
        checks++; if (pending !== 3'd3) begin failures++; $display("FAIL pushpop_pending got=%0d exp=3", pending); end
        for (int k = 1; k < 5; k++) begin
            checks++;
            if (rf_en !== 1'b1 || rf_rd !== 5'(10 + k) || rf_wdata !== 32'(256 + k)) begin
                failures++; $display("FAIL drain%0d got en=%0b rd=%0d d=%0d exp en=1 rd=%0d d=%0d", k, rf_en, rf_rd, rf_wdata, 10 + k, 256 + k);
            end
            if (k < 4) tick();
        end
        checks++; if (pending !== '0) begin failures++; $display("FAIL drain_empty got=%0d exp=0", pending); end
        tick();
    endtask

    task automatic test_waw_kill();
        alu_valid = 1'b1; alu_rd = 5'd1; alu_wdata = 32'h1;
        lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_wdata = 32'hAAAA;
        tick();
        lsu_valid = 1'b0;
        alu_rd = 5'd7; alu_wdata = 32'hBBBB;
        tick();
        alu_valid = 1'b0;
        checks++; if (rf_en !== 1'b1 || rf_rd !== 5'd7 || rf_wdata !== 32'hBBBB) begin failures++; $display("FAIL waw_alu got en=%0b rd=%0d d=%h exp en=1 rd=7 d=bbbb", rf_en, rf_rd, rf_wdata); end
        checks++; if (pending !== 3'd1) begin failures++; $display("FAIL waw_pending got=%0d exp=1", pending); end
        rs1 = 5'd7; #1;
        checks++; if (fwd1_hit !== 1'b1 || fwd1_data !== 32'hBBBB) begin failures++; $display("FAIL waw_fwd got hit=%0b d=%h exp hit=1 d=bbbb", fwd1_hit, fwd1_data); end
        tick();
        checks++; if (rf_en !== 1'b0) begin failures++; $display("FAIL waw_killed_en got=%0b exp=0", rf_en); end
        checks++; if (pending !== '0) begin failures++; $display("FAIL waw_drained got=%0d exp=0", pending); end
        rs1 = 5'd0;
        tick();
    endtask

    task automatic test_forward();
        alu_valid = 1'b1; alu_rd = 5'd1; alu_wdata = 32'h5555;
        lsu_valid = 1'b1; lsu_rd = 5'd3; lsu_wdata = 32'h11;
        tick();
        lsu_wdata = 32'h22;
        tick();
        lsu_valid = 1'b0;
        rs1 = 5'd3; rs2 = 5'd0; #1;
        checks++; if (fwd1_hit !== 1'b1 || fwd1_data !== 32'h22) begin failures++; $display("FAIL fwd_young got hit=%0b d=%h exp hit=1 d=22", fwd1_hit, fwd1_data); end
        checks++; if (fwd2_hit !== 1'b0 || fwd2_data !== '0) begin failures++; $display("FAIL fwd_x0 got hit=%0b d=%h exp hit=0 d=0", fwd2_hit, fwd2_data); end
        rs2 = 5'd1; #1;
        checks++; if (fwd2_hit !== 1'b1 || fwd2_data !== 32'h5555) begin failures++; $display("FAIL fwd_outreg got hit=%0b d=%h exp hit=1 d=5555", fwd2_hit, fwd2_data); end
        alu_valid = 1'b0;
        tick();
        checks++; if (fwd1_hit !== 1'b1 || fwd1_data !== 32'h22) begin failures++; $display("FAIL fwd_after_pop got hit=%0b d=%h exp hit=1 d=22", fwd1_hit, fwd1_data); end
        tick();
        checks++; if (fwd1_hit !== 1'b1 || fwd1_data !== 32'h22 || rf_rd !== 5'd3) begin failures++; $display("FAIL fwd_from_reg got hit=%0b d=%h exp hit=1 d=22", fwd1_hit, fwd1_data); end
        tick();
        checks++; if (fwd1_hit !== 1'b0) begin failures++; $display("FAIL fwd_gone got hit=%0b exp=0", fwd1_hit); end
        rs1 = 5'd0; rs2 = 5'd0;
    endtask

    task automatic test_rd_zero();
        alu_valid = 1'b1; alu_rd = 5'd0; alu_wdata = 32'hFFFF;
        lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_wdata = 32'h1234;
        #1;
        checks++; if (lsu_ready !== 1'b1) begin failures++; $display("FAIL x0_ready got=%0b exp=1", lsu_ready); end
        tick();
        checks++; if (rf_en !== 1'b0) begin failures++; $display("FAIL x0_en got=%0b exp=0", rf_en); end
        checks++; if (pending !== '0) begin failures++; $display("FAIL x0_pending got=%0d exp=0", pending); end
        tick();
        checks++; if (rf_en !== 1'b0 || pending !== '0) begin failures++; $display("FAIL x0_hold got en=%0b pend=%0d exp en=0 pend=0", rf_en, pending); end
        idle_inputs();
    endtask

    task automatic test_async_reset();
        alu_valid = 1'b1; alu_rd = 5'd1; alu_wdata = 32'h77;
        lsu_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            lsu_rd = 5'(20 + k); lsu_wdata = 32'(k);
            tick();
        end
        checks++; if (pending !== 3'd3 || rf_en !== 1'b1) begin failures++; $display("FAIL pre_rst got pend=%0d en=%0b exp pend=3 en=1", pending, rf_en); end
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        checks++; if (rf_en !== 1'b0 || pending !== '0 || rf_rd !== 5'd0) begin failures++; $display("FAIL async_rst got en=%0b pend=%0d rd=%0d exp 0 0 0", rf_en, pending, rf_rd); end
        idle_inputs();
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++; if (rf_en !== 1'b0 || pending !== '0) begin failures++; $display("FAIL post_rst%0d got en=%0b pend=%0d exp 0 0", k, rf_en, pending); end
        end
    endtask

    task automatic test_random();
        logic [XLEN:0] e1, e2;
        for (int n = 0; n < 500; n++) begin
            alu_valid = ($urandom_range(0, 9) < 4);
            alu_rd    = 5'($urandom_range(0, 7));
            alu_wdata = $urandom;
            lsu_valid = ($urandom_range(0, 9) < 6);
            lsu_rd    = 5'($urandom_range(0, 7));
            lsu_wdata = $urandom;
            rs1       = 5'($urandom_range(0, 7));
            rs2       = 5'($urandom_range(0, 7));
            #1;
            e1 = model_fwd(rs1);
            e2 = model_fwd(rs2);
            checks++; if (lsu_ready !== (mq.size() < DEPTH)) begin failures++; $display("FAIL rnd_ready n=%0d got=%0b exp=%0b", n, lsu_ready, mq.size() < DEPTH); end
            checks++; if (pending !== 3'(mq.size())) begin failures++; $display("FAIL rnd_pending n=%0d got=%0d exp=%0d", n, pending, mq.size()); end
            checks++; if ({fwd1_hit, fwd1_data} !== e1) begin failures++; $display("FAIL rnd_fwd1 n=%0d rs=%0d got=%0b/%h exp=%0b/%h", n, rs1, fwd1_hit, fwd1_data, e1[XLEN], e1[XLEN-1:0]); end
            checks++; if ({fwd2_hit, fwd2_data} !== e2) begin failures++; $display("FAIL rnd_fwd2 n=%0d rs=%0d got=%0b/%h exp=%0b/%h", n, rs2, fwd2_hit, fwd2_data, e2[XLEN], e2[XLEN-1:0]); end
            tick();
            checks++; if (rf_en !== m_en) begin failures++; $display("FAIL rnd_en n=%0d got=%0b exp=%0b", n, rf_en, m_en); end
            if (m_en) begin
                checks++; if (rf_rd !== m_rd || rf_wdata !== m_wd) begin failures++; $display("FAIL rnd_write n=%0d got rd=%0d d=%h exp rd=%0d d=%h", n, rf_rd, rf_wdata, m_rd, m_wd); end
            end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_alu_single();
        test_fifo_full();
        test_waw_kill();
        test_forward();
        test_rd_zero();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
